delayed_edge_mon: RTL and testbench
===================================

// Module: delayed_edge_mon
// PURPOSE
//   Multi-channel delayed edge monitor. Each channel watches one flag for a selectable edge.
//   On that edge it checks a companion signal immediately, then checks it again a programmable
//   number of cycles later. Pass/fail events and error counters feed the self-checking test harness.
// PARAMETERS
//   NUM_CH   4   number of independent channels
//   DELAY_W  8   width of delay value (cycles)
//   CNT_W    16  width of saturating error counter
//   TS_W     32  timestamp width (DELAYED_EDGE_MON_TIMESTAMP_EN only)
// PORTS
//   clk         in   1           sole clock, rising edge
//   rst_n       in   1           asynchronous, active-low reset
//   en          in   1           global enable; low cancels all in-flight checks
//   clr         in   1           clears err_sticky, overrun, err_cnt
//   mode        in   2*NUM_CH    per channel: 00 off, 01 posedge, 10 negedge, 11 anyedge
//   delay       in   DELAY_W     post-check delay, sampled per channel at its edge
//   watch       in   NUM_CH      monitored flags
//   check       in   NUM_CH      companion signals under test
//   exp_pre     in   NUM_CH      required check value at edge cycle
//   exp_post    in   NUM_CH      required check value at post-check cycle
//   busy        out  NUM_CH      channel in WAIT or CHK
//   pass_pulse  out  NUM_CH      1-cycle pulse, both checks passed
//   fail_pulse  out  NUM_CH      1-cycle pulse, pre- or post-check failed
//   err_sticky  out  NUM_CH      set on fail, cleared only by clr/reset
//   overrun     out  NUM_CH      sticky: edge arrived while channel busy
//   err_cnt     out  CNT_W       saturating total of fail pulses
// BEHAVIOUR
//   - Reset: all outputs 0, channels IDLE, watch_q 0, primed 0.
//   - Edge detect: watch_q registers watch. primed sets one cycle after reset.
//     No edge is detected while primed=0, so there is no spurious edge out of reset.
//   - Per-channel FSM: IDLE -> WAIT -> CHK -> IDLE.
//   - IDLE, qualifying edge at cycle T with en=1:
//     - check==exp_pre: latch delay into ctr and exp_post, go WAIT.
//     - Otherwise: fail_pulse at T+1, stay IDLE.
//   - WAIT: ctr==0 -> CHK; else ctr-1. delay=D puts CHK at cycle T+1+D (D=0 -> T+1).
//   - CHK: sample check against latched exp_post; pass_pulse or fail_pulse at next cycle; go IDLE.
//   - Qualifying edge in WAIT or CHK: overrun set, edge dropped. In-flight check unaffected, no re-arm.
//   - mode or delay change mid-flight does not affect the in-flight check.
//   - mode=00: edges ignored; an in-flight check still completes.
//   - en=0: all channels forced IDLE at next edge, no pulses. watch_q keeps tracking.
//   - err_cnt += popcount(fail_pulse) each cycle, saturating at all-ones.
//   - clr and fail in the same cycle: err_cnt = popcount(new fails), sticky = new fails.
//   - Channels fully independent; simultaneous events on all channels are legal.
//   - Reset mid-operation: immediate return to the reset state; no pulse emitted.
// CONFIGURATION
//   DELAYED_EDGE_MON_TIMESTAMP_EN defined:
//     - free-running TS_W counter (wraps), reset 0.
//     - extra outputs: first_err_ts[TS_W] and first_err_ch[$clog2(NUM_CH)].
//     - Both capture at the first fail after reset/clr. Lowest channel index wins ties.
//     - first_err_vld[1] is set with the capture, cleared by clr.
//   Not defined: counter and the three ports are absent; all else identical.
// STRUCTURE
//   delayed_edge_mon_pkg:
//     - edge_mode_e (OFF/POS/NEG/ANY)
//     - ch_state_e (IDLE/WAIT/CHK)
//     - function edge_hit(mode, cur, prev)
//   Sub-module delayed_edge_mon_ch: one channel FSM, ctr, exp latch, pulses, sticky bits.
//   Top instantiates NUM_CH channels plus shared primed, err_cnt and timestamp logic.
// TESTING
//   1 Reset, hold watch=1 from cycle 0 -> no pulse, busy=0.
//   2 ch0 mode=01, delay=3; rise watch at T with check=0 (exp_pre=0), check=1 by T+4 (exp_post=1)
//     -> busy T+1..T+4, pass_pulse[0] at T+5.
//   3 As scenario 2 but check stays 0 -> fail_pulse[0] at T+5, err_sticky[0]=1, err_cnt=1.
//   4 mode=11, delay=5; toggle watch at T and T+2
//     -> overrun[0]=1, a single result pulse at T+7.
//   5 delay=0, all 4 channels fail at the same cycle -> err_cnt=4; with err_cnt at 0xFFFE -> 0xFFFF.
//   6 Deassert rst_n mid-WAIT and clr during a fail cycle -> outputs 0 / err_cnt=1; with
//     TIMESTAMP_EN, first_err_ch matches the lowest failing channel.

Source files
------------

// File: rtl/delayed_edge_mon_pkg.sv
// Shared types and helpers for the delayed edge monitor.
// edge_mode_e encodes the per-channel edge selection as driven on the mode port.
// ch_state_e is the per-channel FSM state; edge_hit() qualifies one flag against its mode.
package delayed_edge_mon_pkg;

  typedef enum logic [1:0] {
    EM_OFF = 2'b00,
    EM_POS = 2'b01,
    EM_NEG = 2'b10,
    EM_ANY = 2'b11
  } edge_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_CHK  = 2'b10
  } ch_state_e;

  function automatic logic edge_hit(edge_mode_e mode, logic cur, logic prev);
    case (mode)
      EM_POS:  return cur & ~prev;
      EM_NEG:  return ~cur & prev;
      EM_ANY:  return cur ^ prev;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/delayed_edge_mon_ch.sv
// One monitor channel: edge detect, pre-check, delay countdown, post-check, sticky flags.
// Ports: clk/rst_n, en_i/clr_i/primed_i shared controls, per-channel mode/delay/watch/check/
//   expectations in; busy_o, pass_o/fail_o (1-cycle pulses), sticky_o, overrun_o out.
module delayed_edge_mon_ch
  import delayed_edge_mon_pkg::*;
#(
  parameter int DELAY_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic               primed_i,
  input  logic [1:0]         mode_i,
  input  logic [DELAY_W-1:0] delay_i,
  input  logic               watch_i,
  input  logic               check_i,
  input  logic               exp_pre_i,
  input  logic               exp_post_i,
  output logic               busy_o,
  output logic               pass_o,
  output logic               fail_o,
  output logic               sticky_o,
  output logic               overrun_o
);

  ch_state_e          state_q, state_d;
  logic [DELAY_W-1:0] ctr_q, ctr_d;
  logic               exp_q, exp_d;
  logic               watch_q;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               sticky_q, ovr_q;
  logic               ovr_evt;
  logic               hit;

  // primed_i masks the first cycle out of reset, when watch_q has not yet seen watch_i.
  assign hit = en_i & primed_i & edge_hit(edge_mode_e'(mode_i), watch_i, watch_q);

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    exp_d   = exp_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    ovr_evt = 1'b0;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            if (check_i == exp_pre_i) begin
              exp_d = exp_post_i;
              // The counter holds the remaining WAIT cycles after this one, so the
              // post-check lands exactly delay cycles after the first busy cycle.
              if (delay_i == '0) begin
                state_d = ST_CHK;
              end else begin
                state_d = ST_WAIT;
                ctr_d   = delay_i - DELAY_W'(1);
              end
            end else begin
              fail_d = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          ovr_evt = hit;
          if (ctr_q == '0) state_d = ST_CHK;
          else             ctr_d   = ctr_q - DELAY_W'(1);
        end
        ST_CHK: begin
          ovr_evt = hit;
          pass_d  = (check_i == exp_q);
          fail_d  = (check_i != exp_q);
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ctr_q    <= '0;
      exp_q    <= 1'b0;
      watch_q  <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      sticky_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      exp_q    <= exp_d;
      watch_q  <= watch_i;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      // A fail visible in the clr cycle survives the clear.
      sticky_q <= (clr_i ? 1'b0 : sticky_q) | fail_q;
      ovr_q    <= (clr_i ? 1'b0 : ovr_q) | ovr_evt;
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign pass_o    = pass_q;
  assign fail_o    = fail_q;
  assign sticky_o  = sticky_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/delayed_edge_mon.sv
// Multi-channel delayed edge monitor: NUM_CH channels plus shared primed flag and error counter.
// Ports: clk, rst_n, en, clr, mode, delay, watch, check, exp_pre, exp_post in; busy, pass_pulse,
//   fail_pulse, err_sticky, overrun, err_cnt out. DELAYED_EDGE_MON_TIMESTAMP_EN adds first_err_*.
module delayed_edge_mon
  import delayed_edge_mon_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DELAY_W = 8,
  parameter int CNT_W   = 16
`ifdef DELAYED_EDGE_MON_TIMESTAMP_EN
  , parameter int TS_W  = 32
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr,
  input  logic [2*NUM_CH-1:0]         mode,
  input  logic [DELAY_W-1:0]          delay,
  input  logic [NUM_CH-1:0]           watch,
  input  logic [NUM_CH-1:0]           check,
  input  logic [NUM_CH-1:0]           exp_pre,
  input  logic [NUM_CH-1:0]           exp_post,
  output logic [NUM_CH-1:0]           busy,
  output logic [NUM_CH-1:0]           pass_pulse,
  output logic [NUM_CH-1:0]           fail_pulse,
  output logic [NUM_CH-1:0]           err_sticky,
  output logic [NUM_CH-1:0]           overrun,
  output logic [CNT_W-1:0]            err_cnt
`ifdef DELAYED_EDGE_MON_TIMESTAMP_EN
  , output logic [TS_W-1:0]           first_err_ts,
  output logic [$clog2(NUM_CH)-1:0]   first_err_ch,
  output logic                        first_err_vld
`endif
);

  localparam int PC_W = $clog2(NUM_CH + 1);

  logic             primed_q;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, cnt_base;
  logic [CNT_W:0]   cnt_sum;
  logic [PC_W-1:0]  fail_pc;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    delayed_edge_mon_ch #(.DELAY_W(DELAY_W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en),
      .clr_i      (clr),
      .primed_i   (primed_q),
      .mode_i     (mode[2*g +: 2]),
      .delay_i    (delay),
      .watch_i    (watch[g]),
      .check_i    (check[g]),
      .exp_pre_i  (exp_pre[g]),
      .exp_post_i (exp_post[g]),
      .busy_o     (busy[g]),
      .pass_o     (pass_pulse[g]),
      .fail_o     (fail_pulse[g]),
      .sticky_o   (err_sticky[g]),
      .overrun_o  (overrun[g])
    );
  end

  always_comb begin
    fail_pc = '0;
    for (int i = 0; i < NUM_CH; i++) fail_pc = fail_pc + PC_W'(fail_pulse[i]);
  end

  // One extra sum bit catches the carry out; any carry means the counter saturates.
  assign cnt_base  = clr ? '0 : err_cnt_q;
  assign cnt_sum   = {1'b0, cnt_base} + (CNT_W+1)'(fail_pc);
  assign err_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      primed_q  <= 1'b1;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

`ifdef DELAYED_EDGE_MON_TIMESTAMP_EN
  localparam int CH_W = $clog2(NUM_CH);

  logic [TS_W-1:0] ts_q, fe_ts_q;
  logic [CH_W-1:0] fe_ch_q, lo_ch;
  logic            fe_vld_q, any_fail, cap;

  // Scan downwards so the lowest failing channel is the one left in lo_ch.
  always_comb begin
    lo_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fail_pulse[i]) lo_ch = CH_W'(i);
    end
  end

  assign any_fail = |fail_pulse;
  assign cap      = any_fail & (clr | ~fe_vld_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      fe_ts_q  <= '0;
      fe_ch_q  <= '0;
      fe_vld_q <= 1'b0;
    end else begin
      ts_q     <= ts_q + TS_W'(1);
      fe_vld_q <= (clr ? 1'b0 : fe_vld_q) | any_fail;
      if (cap) begin
        fe_ts_q <= ts_q;
        fe_ch_q <= lo_ch;
      end
    end
  end

  assign first_err_ts  = fe_ts_q;
  assign first_err_ch  = fe_ch_q;
  assign first_err_vld = fe_vld_q;
`endif

endmodule

// File: tb/tb_delayed_edge_mon.sv
// Self-checking bench for delayed_edge_mon: directed scenarios plus a randomized run
// against a cycle-number based reference model of each channel's checks.
// Ports of the DUT are all driven/observed here; timestamp ports only when enabled.
module tb_delayed_edge_mon;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, clr;
  logic [7:0]  mode, delay;
  logic [3:0]  watch, check, exp_pre, exp_post;
  logic [3:0]  busy, pass_pulse, fail_pulse, err_sticky, overrun;
  logic [15:0] err_cnt;
`ifdef DELAYED_EDGE_MON_TIMESTAMP_EN
  logic [31:0] first_err_ts;
  logic [1:0]  first_err_ch;
  logic        first_err_vld;
`endif

  int total = 0;
  int bad   = 0;

  delayed_edge_mon dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .delay(delay),
    .watch(watch), .check(check), .exp_pre(exp_pre), .exp_post(exp_post),
    .busy(busy), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
    .err_sticky(err_sticky), .overrun(overrun), .err_cnt(err_cnt)
`ifdef DELAYED_EDGE_MON_TIMESTAMP_EN
    , .first_err_ts(first_err_ts), .first_err_ch(first_err_ch), .first_err_vld(first_err_vld)
`endif
  );

  // Reference model: each in-flight check is an arm cycle and a post-check cycle number.
  bit         m_primed;
  int         m_cyc;
  bit         m_infl [4];
  int         m_arm  [4];
  int         m_chk  [4];
  bit         m_exp  [4];
  bit         m_wq   [4];
  logic [3:0] e_busy, e_pass, e_fail, e_sticky, e_ovr;
  int         e_cnt;
  int         e_first_ch;
  bit         e_first_vld;

  function automatic bit m_edge(input logic [1:0] md, input bit cur, input bit prev);
    case (md)
      2'b01:   return cur && !prev;
      2'b10:   return !cur && prev;
      2'b11:   return cur != prev;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int pc4(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic m_reset();
    m_primed = 0; m_cyc = 0;
    for (int c = 0; c < 4; c++) begin
      m_infl[c] = 0; m_arm[c] = 0; m_chk[c] = 0; m_exp[c] = 0; m_wq[c] = 0;
    end
    e_busy = 0; e_pass = 0; e_fail = 0; e_sticky = 0; e_ovr = 0; e_cnt = 0;
    e_first_ch = 0; e_first_vld = 0;
  endtask

  // Advance the model over the current cycle's inputs, then clock the DUT.
  task automatic tick();
    logic [3:0] nf, np, novr;
    bit hit, bn;
    nf = 0; np = 0; novr = 0;
    for (int c = 0; c < 4; c++) begin
      hit = m_primed && en && m_edge(mode[2*c +: 2], watch[c], m_wq[c]);
      bn  = m_infl[c] && m_arm[c] < m_cyc && m_cyc <= m_chk[c];
      if (!en) begin
        m_infl[c] = 0;
      end else begin
        if (m_infl[c] && m_cyc == m_chk[c]) begin
          if (check[c] == m_exp[c]) np[c] = 1; else nf[c] = 1;
          m_infl[c] = 0;
        end
        if (hit) begin
          if (bn) novr[c] = 1;
          else if (check[c] == exp_pre[c]) begin
            m_infl[c] = 1; m_arm[c] = m_cyc; m_chk[c] = m_cyc + 1 + int'(delay);
            m_exp[c] = exp_post[c];
          end else nf[c] = 1;
        end
      end
      m_wq[c] = watch[c];
    end
    m_primed = 1;
    e_sticky = (clr ? 4'h0 : e_sticky) | e_fail;
    e_ovr    = (clr ? 4'h0 : e_ovr) | novr;
    e_cnt    = (clr ? 0 : e_cnt) + pc4(e_fail);
    if (e_cnt > 65535) e_cnt = 65535;
    if (e_fail != 0 && (clr || !e_first_vld)) begin
      for (int c = 3; c >= 0; c--) if (e_fail[c]) e_first_ch = c;
    end
    e_first_vld = (clr ? 1'b0 : e_first_vld) | (e_fail != 0);
    e_fail = nf; e_pass = np;
    m_cyc++;
    for (int c = 0; c < 4; c++) e_busy[c] = m_infl[c] && m_arm[c] < m_cyc && m_cyc <= m_chk[c];
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    en = 1; clr = 0; mode = 8'hFF; delay = 0; watch = 4'hF;
    check = 4'h0; exp_pre = 4'hF; exp_post = 4'h0;
    rst_n = 0;
    #1;
    total++;
    if ({busy, pass_pulse, fail_pulse, err_sticky, overrun} !== 20'h0 || err_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_hold busy=%h pass=%h fail=%h sticky=%h ovr=%h cnt=%0d required all 0",
               busy, pass_pulse, fail_pulse, err_sticky, overrun, err_cnt);
    end
    do_reset();
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({busy, pass_pulse, fail_pulse, err_sticky, overrun} !== 20'h0 || err_cnt !== 16'h0) begin
        bad++;
        $display("FAIL reset_quiet k=%0d busy=%h pass=%h fail=%h cnt=%0d required all 0",
                 k, busy, pass_pulse, fail_pulse, err_cnt);
      end
      tick();
    end
  endtask

  task automatic test_pass();
    en = 1; clr = 0; mode = 8'h01; delay = 3; watch = 0; check = 0; exp_pre = 0; exp_post = 4'h1;
    do_reset(); tick(); tick();
    watch[0] = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 2) check[0] = 1;
      total++;
      if (busy[0] !== (k <= 4)) begin
        bad++; $display("FAIL pass_busy T+%0d got=%b required=%b", k, busy[0], k <= 4);
      end
      total++;
      if (pass_pulse !== ((k == 5) ? 4'h1 : 4'h0) || fail_pulse !== 4'h0) begin
        bad++;
        $display("FAIL pass_pulse T+%0d pass=%h fail=%h required pass=%h fail=0",
                 k, pass_pulse, fail_pulse, (k == 5) ? 4'h1 : 4'h0);
      end
    end
  endtask

  task automatic test_fail();
    en = 1; clr = 0; mode = 8'h01; delay = 3; watch = 0; check = 0; exp_pre = 0; exp_post = 4'h1;
    do_reset(); tick(); tick();
    watch[0] = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (fail_pulse !== ((k == 5) ? 4'h1 : 4'h0) || pass_pulse !== 4'h0) begin
        bad++;
        $display("FAIL fail_pulse T+%0d fail=%h pass=%h required fail=%h pass=0",
                 k, fail_pulse, pass_pulse, (k == 5) ? 4'h1 : 4'h0);
      end
    end
    total++;
    if (err_sticky !== 4'h1 || err_cnt !== 16'd1) begin
      bad++; $display("FAIL fail_count sticky=%h cnt=%0d required sticky=1 cnt=1", err_sticky, err_cnt);
    end
  endtask

  task automatic test_overrun();
    en = 1; clr = 0; mode = 8'h03; delay = 5; watch = 0; check = 0; exp_pre = 0; exp_post = 0;
    do_reset(); tick(); tick();
    watch[0] = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 2) watch[0] = 0;
      total++;
      if (overrun[0] !== (k >= 3)) begin
        bad++; $display("FAIL ovr_flag T+%0d got=%b required=%b", k, overrun[0], k >= 3);
      end
      total++;
      if (pass_pulse !== ((k == 7) ? 4'h1 : 4'h0) || fail_pulse !== 4'h0) begin
        bad++;
        $display("FAIL ovr_result T+%0d pass=%h fail=%h required pass=%h fail=0",
                 k, pass_pulse, fail_pulse, (k == 7) ? 4'h1 : 4'h0);
      end
    end
  endtask

  task automatic test_all_fail();
    en = 1; clr = 0; mode = 8'h55; delay = 0; watch = 0; check = 4'hF; exp_pre = 0; exp_post = 0;
    do_reset(); tick(); tick();
    watch = 4'hF;
    tick();
    total++;
    if (fail_pulse !== 4'hF) begin
      bad++; $display("FAIL all_fail_pulse got=%h required=f", fail_pulse);
    end
    tick();
    total++;
    if (err_cnt !== 16'd4 || err_sticky !== 4'hF) begin
      bad++; $display("FAIL all_fail_cnt cnt=%0d sticky=%h required cnt=4 sticky=f", err_cnt, err_sticky);
    end
    mode = 8'hFF;
    for (int n = 0; n < 16382; n++) begin
      watch = ~watch;
      tick();
    end
    tick(); tick();
    total++;
    if (err_cnt !== 16'hFFFC) begin
      bad++; $display("FAIL cnt_fffc got=%h required=fffc", err_cnt);
    end
    mode = 8'h0F;
    watch = ~watch;
    tick(); tick(); tick();
    total++;
    if (err_cnt !== 16'hFFFE) begin
      bad++; $display("FAIL cnt_fffe got=%h required=fffe", err_cnt);
    end
    mode = 8'hFF;
    watch = ~watch;
    tick(); tick(); tick();
    total++;
    if (err_cnt !== 16'hFFFF) begin
      bad++; $display("FAIL cnt_sat got=%h required=ffff", err_cnt);
    end
    watch = ~watch;
    tick(); tick(); tick();
    total++;
    if (err_cnt !== 16'hFFFF) begin
      bad++; $display("FAIL cnt_sat_hold got=%h required=ffff", err_cnt);
    end
  endtask

  task automatic test_reset_mid_and_clr();
    en = 1; clr = 0; mode = 8'h01; delay = 10; watch = 0; check = 0; exp_pre = 0; exp_post = 0;
    do_reset(); tick(); tick();
    watch[0] = 1;
    tick(); tick(); tick();
    total++;
    if (busy[0] !== 1'b1) begin
      bad++; $display("FAIL mid_busy got=%b required=1", busy[0]);
    end
    rst_n = 0;
    m_reset();
    #1;
    total++;
    if ({busy, pass_pulse, fail_pulse, err_sticky, overrun} !== 20'h0 || err_cnt !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset busy=%h pass=%h fail=%h cnt=%0d required all 0",
               busy, pass_pulse, fail_pulse, err_cnt);
    end
    @(posedge clk); #1 rst_n = 1;
    for (int k = 0; k < 14; k++) begin
      tick();
      total++;
      if (pass_pulse !== 4'h0 || fail_pulse !== 4'h0 || busy !== 4'h0) begin
        bad++;
        $display("FAIL mid_quiet k=%0d pass=%h fail=%h busy=%h required 0", k, pass_pulse, fail_pulse, busy);
      end
    end
    mode = 8'h55; delay = 0; watch = 0; check = 4'b0001;
    tick();
    watch = 4'b0001;
    tick(); tick();
    total++;
    if (err_cnt !== 16'd1) begin
      bad++; $display("FAIL clr_pre_cnt got=%0d required=1", err_cnt);
    end
    watch = 4'b0011; check = 4'b0010;
    tick();
    clr = 1;
    tick();
    clr = 0;
    total++;
    if (err_cnt !== 16'd1 || err_sticky !== 4'b0010) begin
      bad++; $display("FAIL clr_with_fail cnt=%0d sticky=%h required cnt=1 sticky=2", err_cnt, err_sticky);
    end
`ifdef DELAYED_EDGE_MON_TIMESTAMP_EN
    total++;
    if (first_err_vld !== 1'b1 || first_err_ch !== 2'd1) begin
      bad++; $display("FAIL first_ch_clr vld=%b ch=%0d required vld=1 ch=1", first_err_vld, first_err_ch);
    end
`endif
    clr = 1;
    tick();
    clr = 0;
    check = 4'b1100; watch = 4'b1111;
    tick(); tick();
    total++;
    if (err_cnt !== 16'd2 || err_sticky !== 4'b1100) begin
      bad++; $display("FAIL tie_cnt cnt=%0d sticky=%h required cnt=2 sticky=c", err_cnt, err_sticky);
    end
`ifdef DELAYED_EDGE_MON_TIMESTAMP_EN
    total++;
    if (first_err_vld !== 1'b1 || first_err_ch !== 2'd2) begin
      bad++; $display("FAIL first_ch_tie vld=%b ch=%0d required vld=1 ch=2", first_err_vld, first_err_ch);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] flip;
    en = 1; clr = 0; mode = 0; delay = 0; watch = 0; check = 0; exp_pre = 0; exp_post = 0;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      en  = ($urandom_range(0, 19) != 0);
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) mode = 8'($urandom);
      delay = 8'($urandom_range(0, 6));
      for (int c = 0; c < 4; c++) flip[c] = ($urandom_range(0, 3) == 0);
      watch    = watch ^ flip;
      check    = 4'($urandom);
      exp_pre  = 4'($urandom);
      exp_post = 4'($urandom);
      tick();
      total++;
      if (busy !== e_busy || pass_pulse !== e_pass || fail_pulse !== e_fail) begin
        bad++;
        $display("FAIL rnd_pulse cyc=%0d busy=%h pass=%h fail=%h required busy=%h pass=%h fail=%h",
                 n, busy, pass_pulse, fail_pulse, e_busy, e_pass, e_fail);
      end
      total++;
      if (err_sticky !== e_sticky || overrun !== e_ovr || err_cnt !== 16'(e_cnt)) begin
        bad++;
        $display("FAIL rnd_flags cyc=%0d sticky=%h ovr=%h cnt=%0d required sticky=%h ovr=%h cnt=%0d",
                 n, err_sticky, overrun, err_cnt, e_sticky, e_ovr, e_cnt);
      end
`ifdef DELAYED_EDGE_MON_TIMESTAMP_EN
      total++;
      if (first_err_vld !== e_first_vld || (e_first_vld && first_err_ch !== 2'(e_first_ch))) begin
        bad++;
        $display("FAIL rnd_first cyc=%0d vld=%b ch=%0d required vld=%b ch=%0d",
                 n, first_err_vld, first_err_ch, e_first_vld, e_first_ch);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_overrun();
    test_all_fail();
    test_reset_mid_and_clr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
